// File: rtl/fm_product_buffer.sv
// Stores the multiplier's dot products row-major into a NUM_NODES x OUT_COLS matrix and serves it through a registered read port.
// Optional FM_BUF_ARGMAX_EN adds per-row argmax tracking; when undefined, rd_argmax is tied to 0.
module fm_product_buffer #(
  parameter int DOT_PROD_WIDTH = 16,
  parameter int NUM_NODES      = 6,
  parameter int OUT_COLS       = 3,
  parameter int ROW_W          = $clog2(NUM_NODES),
  parameter int COL_W          = $clog2(OUT_COLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      prod_valid,
  input  logic [DOT_PROD_WIDTH-1:0] PRODUCT,
  output logic                      prod_ready,
  output logic                      fill_done,
  input  logic                      rd_en,
  input  logic [ROW_W-1:0]          rd_row,
  input  logic [COL_W-1:0]          rd_col,
  output logic [DOT_PROD_WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  output logic [COL_W-1:0]          rd_argmax
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_NODES - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);

  state_t                      state_q;
  logic [ROW_W-1:0]            row_q;
  logic [COL_W-1:0]            col_q;
  logic                        fill_done_q;
  logic [DOT_PROD_WIDTH-1:0]   mem_q [NUM_NODES][OUT_COLS];
  logic [DOT_PROD_WIDTH-1:0]   rd_data_q;
  logic                        rd_valid_q;
  logic                        accept;
  logic                        last_elem;
  logic                        rd_fire;
  logic                        row_ok;
  logic                        col_ok;

  // A product arriving together with start belongs to no fill and is dropped.
  assign prod_ready = (state_q == FILL);
  assign accept     = prod_valid && prod_ready && !start;
  assign last_elem  = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign rd_fire    = rd_en && fill_done_q;
  assign row_ok     = int'(rd_row) < NUM_NODES;
  assign col_ok     = int'(rd_col) < OUT_COLS;

  assign fill_done  = fill_done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      fill_done_q <= 1'b0;
    end else if (start) begin
      state_q     <= FILL;
      row_q       <= '0;
      col_q       <= '0;
      fill_done_q <= 1'b0;
    end else if (accept) begin
      if (last_elem) begin
        state_q     <= FULL;
        row_q       <= '0;
        col_q       <= '0;
        fill_done_q <= 1'b1;
      end else if (col_q == LAST_COL) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Matrix storage is deliberately left out of reset; every fill overwrites it completely.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[row_q][col_q] <= PRODUCT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= (row_ok && col_ok) ? mem_q[rd_row][rd_col] : '0;
      end
    end
  end

`ifdef FM_BUF_ARGMAX_EN
  logic [COL_W-1:0] argmax_q [NUM_NODES];
  logic [COL_W-1:0] rd_argmax_q;

  // Running argmax compares against the stored value of the current winner; strict
  // greater-than keeps the lowest column on ties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        argmax_q[i] <= '0;
      end
      rd_argmax_q <= '0;
    end else begin
      if (start) begin
        for (int i = 0; i < NUM_NODES; i++) begin
          argmax_q[i] <= '0;
        end
      end else if (accept) begin
        if (col_q == '0) begin
          argmax_q[row_q] <= '0;
        end else if (PRODUCT > mem_q[row_q][argmax_q[row_q]]) begin
          argmax_q[row_q] <= col_q;
        end
      end
      if (rd_fire) begin
        rd_argmax_q <= row_ok ? argmax_q[rd_row] : '0;
      end
    end
  end

  assign rd_argmax = rd_argmax_q;
`else
  assign rd_argmax = '0;
`endif

endmodule

// File: tb/tb_fm_product_buffer.sv
// Self-checking bench for fm_product_buffer: a scoreboard queue holds expected read responses,
// popped and compared one cycle after each read request.
module tb_fm_product_buffer;

  localparam int W  = 16;
  localparam int NR = 6;
  localparam int NC = 3;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] data;
    logic [1:0]   arg;
  } rdExp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         prod_valid;
  logic [W-1:0] PRODUCT;
  logic         prod_ready;
  logic         fill_done;
  logic         rd_en;
  logic [2:0]   rd_row;
  logic [1:0]   rd_col;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [1:0]   rd_argmax;

  int assertCount = 0;
  int failCount   = 0;

  int           expMat [NR][NC];
  int           fillVals [NR*NC];
  logic [W-1:0] lastData;
  logic [1:0]   lastArg;
  rdExp_t       sbQ [$];
  rdExp_t       e;

  fm_product_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prod_valid (prod_valid),
    .PRODUCT    (PRODUCT),
    .prod_ready (prod_ready),
    .fill_done  (fill_done),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_argmax  (rd_argmax)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [1:0] modelArg(int r);
    int best;
    best = 0;
`ifdef FM_BUF_ARGMAX_EN
    for (int c = 1; c < NC; c++) begin
      if (expMat[r][c] > expMat[r][best]) best = c;
    end
`endif
    return 2'(best);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    prod_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic fillMatrix(int fromK, int toK, int gap);
    for (int k = fromK; k < toK; k++) begin
      prod_valid = 1'b1;
      PRODUCT = W'(fillVals[k]);
      expMat[k / NC][k % NC] = fillVals[k];
      tick();
      prod_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic issueRead(int r, int c);
    rdExp_t x;
    if (fill_done === 1'b1) begin
      x.valid = 1'b1;
      x.data  = (r < NR && c < NC) ? W'(expMat[r][c]) : '0;
      x.arg   = (r < NR) ? modelArg(r) : 2'd0;
      lastData = x.data;
      lastArg  = x.arg;
    end else begin
      x.valid = 1'b0;
      x.data  = lastData;
      x.arg   = lastArg;
    end
    sbQ.push_back(x);
    rd_en  = 1'b1;
    rd_row = 3'(r);
    rd_col = 2'(c);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    lastData = '0;
    lastArg  = '0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; prod_valid = 1'b0; PRODUCT = '0;
    rd_en = 1'b0; rd_row = '0; rd_col = '0;
    lastData = '0; lastArg = '0;
    #3;
    assertCount++;
    if ({prod_ready, fill_done, rd_valid, rd_data, rd_argmax} !== {2'b00, 1'b0, 16'h0, 2'b00}) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: actual=%h required=0",
               {prod_ready, fill_done, rd_valid, rd_data, rd_argmax});
    end
    #10;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NR*NC; k++) fillVals[k] = k * 10;
    pulseStart();
    fillMatrix(0, 17, 0);
    assertCount++;
    if (fill_done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_done_early: actual=%b required=0", fill_done);
    end
    fillMatrix(17, 18, 0);
    assertCount++;
    if (fill_done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_done: actual=%b required=1", fill_done);
    end
    issueRead(2, 1);
    e = sbQ.pop_front();
    assertCount++;
    if ({rd_valid, rd_data, rd_argmax} !== e) begin
      failCount++;
      $display("[TB] FAIL b2b_read_2_1: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
    end
    tick();
    assertCount++;
    if (rd_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_rd_valid_pulse: actual=%b required=0", rd_valid);
    end
  endtask

  task automatic test_gapped();
    assertCount++;
    if (prod_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL gap_ready_full: actual=%b required=0", prod_ready);
    end
    applyReset();
    prod_valid = 1'b1;
    PRODUCT = 16'd77;
    #1;
    assertCount++;
    if (prod_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL gap_ready_idle: actual=%b required=0", prod_ready);
    end
    tick();
    prod_valid = 1'b0;
    pulseStart();
    fillMatrix(0, 18, 2);
    assertCount++;
    if (fill_done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL gap_done: actual=%b required=1", fill_done);
    end
    issueRead(4, 2);
    e = sbQ.pop_front();
    assertCount++;
    if ({rd_valid, rd_data, rd_argmax} !== e) begin
      failCount++;
      $display("[TB] FAIL gap_read_4_2: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
    end
  endtask

  task automatic test_full_ignore();
    prod_valid = 1'b1;
    PRODUCT = 16'd999;
    tick();
    prod_valid = 1'b0;
    assertCount++;
    if (fill_done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL full_done_held: actual=%b required=1", fill_done);
    end
    issueRead(5, 2);
    e = sbQ.pop_front();
    assertCount++;
    if ({rd_valid, rd_data, rd_argmax} !== e) begin
      failCount++;
      $display("[TB] FAIL full_read_5_2: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
    end
    issueRead(6, 0);
    e = sbQ.pop_front();
    assertCount++;
    if ({rd_valid, rd_data, rd_argmax} !== e) begin
      failCount++;
      $display("[TB] FAIL full_read_oob_row: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
    end
    issueRead(1, 3);
    e = sbQ.pop_front();
    assertCount++;
    if ({rd_valid, rd_data, rd_argmax} !== e) begin
      failCount++;
      $display("[TB] FAIL full_read_oob_col: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
    end
  endtask

  task automatic test_reset_midfill();
    for (int k = 0; k < NR*NC; k++) fillVals[k] = 1000 + k;
    pulseStart();
    fillMatrix(0, 7, 0);
    reset = 1'b0;
    #1;
    assertCount++;
    if ({prod_ready, fill_done} !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL midfill_async_reset: actual=%b required=00", {prod_ready, fill_done});
    end
    reset = 1'b1;
    lastData = '0;
    lastArg  = '0;
    tick();
    issueRead(0, 0);
    e = sbQ.pop_front();
    assertCount++;
    if ({rd_valid, rd_data, rd_argmax} !== e) begin
      failCount++;
      $display("[TB] FAIL midfill_read_blocked: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
    end
    pulseStart();
    fillMatrix(0, 17, 0);
    assertCount++;
    if (fill_done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midfill_done_early: actual=%b required=0", fill_done);
    end
    fillMatrix(17, 18, 0);
    assertCount++;
    if (fill_done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midfill_done: actual=%b required=1", fill_done);
    end
    issueRead(0, 0);
    issueRead(5, 2);
    for (int i = 0; i < 2; i++) begin
      e = sbQ.pop_front();
      assertCount++;
      if (i == 0) begin
        if (e.data !== 16'd1000 || e.valid !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL midfill_model_0_0: actual=%h required=1000 valid", e);
        end
      end else if ({rd_valid, rd_data, rd_argmax} !== e) begin
        failCount++;
        $display("[TB] FAIL midfill_read_5_2: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
      end
    end
  endtask

  task automatic test_start_collision();
    start = 1'b1;
    prod_valid = 1'b1;
    PRODUCT = 16'd5555;
    tick();
    start = 1'b0;
    prod_valid = 1'b0;
    assertCount++;
    if ({fill_done, prod_ready} !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL collide_state: actual=%b required=01", {fill_done, prod_ready});
    end
    for (int k = 0; k < NR*NC; k++) fillVals[k] = 2000 + k;
    fillMatrix(0, 18, 0);
    issueRead(0, 0);
    e = sbQ.pop_front();
    assertCount++;
    if ({rd_valid, rd_data, rd_argmax} !== e) begin
      failCount++;
      $display("[TB] FAIL collide_read_0_0: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
    end
    issueRead(3, 1);
    e = sbQ.pop_front();
    assertCount++;
    if ({rd_valid, rd_data, rd_argmax} !== e) begin
      failCount++;
      $display("[TB] FAIL collide_read_3_1: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
    end
  endtask

  task automatic test_argmax();
    int rows [5];
    int cols [5];
    fillVals = '{0, 0, 0,  3, 7, 2,  8, 1, 8,  5, 9, 9,  1, 2, 30,  65535, 4, 65535};
    rows = '{3, 0, 2, 4, 7};
    cols = '{1, 2, 2, 0, 0};
    pulseStart();
    fillMatrix(0, 18, 1);
    for (int i = 0; i < 5; i++) begin
      issueRead(rows[i], cols[i]);
      e = sbQ.pop_front();
      assertCount++;
      if ({rd_valid, rd_data, rd_argmax} !== e) begin
        failCount++;
        $display("[TB] FAIL argmax_row%0d: actual=%h required=%h", rows[i],
                 {rd_valid, rd_data, rd_argmax}, e);
      end
    end
    issueRead(1, 0);
    issueRead(5, 1);
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      if (sbQ.size() == 0) begin
        assertCount++;
        if ({rd_valid, rd_data, rd_argmax} !== e) begin
          failCount++;
          $display("[TB] FAIL argmax_tie_row5: actual=%h required=%h", {rd_valid, rd_data, rd_argmax}, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_full_ignore();
    test_reset_midfill();
    test_start_collision();
    test_argmax();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
